// File: rtl/video_pattern_gen.sv
// video_pattern_gen
// Test-pattern raster generator. It produces a pixel enable, H/V sync and
// blanking, and RGB pixels in one of four patterns: mono noise, per-channel
// noise, colour bars, or a scrolling gradient. The pal, scandouble and
// pattern inputs take effect only at the frame boundary. col_mask takes
// effect on the next pixel.
//
// Ports
//   clk_sys      system clock
//   reset_n      asynchronous active-low reset
//   pal          0 = NTSC line count, 1 = PAL line count
//   scandouble   1 = pixel period CE_DIV/2
//   pattern      0 mono noise, 1 per-channel noise, 2 colour bars, 3 gradient
//   col_mask     {R,G,B} channel enable
//   ce_pix       one-clock pixel enable (combinational from the divider)
//   HBlank/VBlank/HSync/VSync  active-high timing outputs (registered)
//   R/G/B        pixel colour (registered)
//   frame_start  one-clock pulse after the raster wraps to (0,0)
//   frame_cnt    frames since reset, modulo 256
module video_pattern_gen #(
  parameter int DW           = 8,
  parameter int HW           = 10,
  parameter int CE_DIV       = 4,
  parameter int H_ACTIVE     = 320,
  parameter int H_TOTAL      = 400,
  parameter int H_SYNC_START = 336,
  parameter int H_SYNC_LEN   = 32,
  parameter int V_ACTIVE     = 240,
  parameter int V_TOTAL_NTSC = 262,
  parameter int V_TOTAL_PAL  = 312,
  parameter int V_SYNC_START = 244,
  parameter int V_SYNC_LEN   = 3
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          pal,
  input  logic          scandouble,
  input  logic [1:0]    pattern,
  input  logic [2:0]    col_mask,
  output logic          ce_pix,
  output logic          HBlank,
  output logic          VBlank,
  output logic          HSync,
  output logic          VSync,
  output logic [DW-1:0] R,
  output logic [DW-1:0] G,
  output logic [DW-1:0] B,
  output logic          frame_start,
  output logic [7:0]    frame_cnt
);

  localparam int DIVW = (CE_DIV > 2) ? $clog2(CE_DIV) : 1;
  localparam logic [DIVW-1:0] DIV_FULL_LAST = DIVW'(CE_DIV - 1);
  localparam logic [DIVW-1:0] DIV_HALF_LAST = DIVW'(CE_DIV / 2 - 1);
  localparam logic [HW-1:0]   H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0]   H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0]   HS_ON    = HW'(H_SYNC_START);
  localparam logic [HW-1:0]   HS_OFF   = HW'(H_SYNC_START + H_SYNC_LEN);
  localparam logic [HW-1:0]   V_ACT    = HW'(V_ACTIVE);
  localparam logic [HW-1:0]   VS_ON    = HW'(V_SYNC_START);
  localparam logic [HW-1:0]   VS_OFF   = HW'(V_SYNC_START + V_SYNC_LEN);
  localparam logic [HW-1:0]   VN_LAST  = HW'(V_TOTAL_NTSC - 1);
  localparam logic [HW-1:0]   VP_LAST  = HW'(V_TOTAL_PAL - 1);
  localparam logic [HW-1:0]   BAR_LAST = HW'(H_ACTIVE / 8 - 1);

  // Galois LFSR step, x^16+x^14+x^13+x^11+1, shifting right
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    lfsr_step = {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  logic [DIVW-1:0] div_r;
  logic [HW-1:0]   hcnt_r, vcnt_r;
  logic [15:0]     l0_r, l1_r, l2_r;
  logic [2:0]      bar_r;
  logic [HW-1:0]   bar_cnt_r;
  logic            pal_r, scan_r;
  logic [1:0]      pattern_r;
  logic [7:0]      frame_cnt_r;
  logic            frame_start_r;
  logic            hblank_r, vblank_r, hsync_r, vsync_r;
  logic [DW-1:0]   r_r, g_r, b_r;

  logic            ce_s, h_last_s, v_last_s, boundary_s, vis_s;
  logic [DIVW-1:0] div_last_s;
  logic            hblank_s, vblank_s, hsync_s, vsync_s;
  logic [HW-1:0]   hcnt_nxt_s, vcnt_nxt_s, bar_cnt_nxt_s;
  logic [2:0]      bar_nxt_s;
  logic [DW-1:0]   grad_s, r_s, g_s, b_s, r_out_s, g_out_s, b_out_s;

  // Raster decode, next-state for counters and bar tracker, and pixel colour
  always_comb begin
    ce_s       = (div_r == {DIVW{1'b0}});
    div_last_s = scan_r ? DIV_HALF_LAST : DIV_FULL_LAST;
    h_last_s   = (hcnt_r == H_LAST);
    v_last_s   = (vcnt_r == (pal_r ? VP_LAST : VN_LAST));
    boundary_s = ce_s & h_last_s & v_last_s;

    hblank_s = (hcnt_r >= H_ACT);
    hsync_s  = (hcnt_r >= HS_ON) && (hcnt_r < HS_OFF);
    vblank_s = (vcnt_r >= V_ACT);
    vsync_s  = (vcnt_r >= VS_ON) && (vcnt_r < VS_OFF);
    vis_s    = ~(hblank_s | vblank_s);

    if (h_last_s) begin
      hcnt_nxt_s = {HW{1'b0}};
      vcnt_nxt_s = v_last_s ? {HW{1'b0}} : vcnt_r + HW'(1);
    end else begin
      hcnt_nxt_s = hcnt_r + HW'(1);
      vcnt_nxt_s = vcnt_r;
    end

    // Bar index for the pixel after this one; restarts with every line.
    if (h_last_s) begin
      bar_cnt_nxt_s = {HW{1'b0}};
      bar_nxt_s     = 3'd0;
    end else if (hcnt_r < H_ACT) begin
      if (bar_cnt_r == BAR_LAST) begin
        bar_cnt_nxt_s = {HW{1'b0}};
        bar_nxt_s     = (bar_r == 3'd7) ? 3'd7 : bar_r + 3'd1;
      end else begin
        bar_cnt_nxt_s = bar_cnt_r + HW'(1);
        bar_nxt_s     = bar_r;
      end
    end else begin
      bar_cnt_nxt_s = bar_cnt_r;
      bar_nxt_s     = bar_r;
    end

    grad_s = DW'(hcnt_r) + DW'(frame_cnt_r);

    case (pattern_r)
      2'd0: begin
        r_s = l0_r[DW-1:0];
        g_s = l0_r[DW-1:0];
        b_s = l0_r[DW-1:0];
      end
      2'd1: begin
        r_s = l0_r[DW-1:0];
        g_s = l1_r[DW-1:0];
        b_s = l2_r[DW-1:0];
      end
      2'd2: begin
        r_s = {DW{~bar_r[1]}};
        g_s = {DW{~bar_r[2]}};
        b_s = {DW{~bar_r[0]}};
      end
      2'd3: begin
        r_s = grad_s;
        g_s = grad_s;
        b_s = grad_s;
      end
      default: begin
        r_s = {DW{1'b0}};
        g_s = {DW{1'b0}};
        b_s = {DW{1'b0}};
      end
    endcase

    r_out_s = (col_mask[2] & vis_s) ? r_s : {DW{1'b0}};
    g_out_s = (col_mask[1] & vis_s) ? g_s : {DW{1'b0}};
    b_out_s = (col_mask[0] & vis_s) ? b_s : {DW{1'b0}};
  end

  // Pixel divider: counts 0..P-1, P chosen by the latched scandouble
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      div_r <= {DIVW{1'b0}};
    end else if (div_r == div_last_s) begin
      div_r <= {DIVW{1'b0}};
    end else begin
      div_r <= div_r + DIVW'(1);
    end
  end

  // Raster counters, bar tracker and noise generators step on every pixel
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      hcnt_r    <= {HW{1'b0}};
      vcnt_r    <= {HW{1'b0}};
      bar_r     <= 3'd0;
      bar_cnt_r <= {HW{1'b0}};
      l0_r      <= 16'hACE1;
      l1_r      <= 16'h1D2C;
      l2_r      <= 16'h5A5A;
    end else if (ce_s) begin
      hcnt_r    <= hcnt_nxt_s;
      vcnt_r    <= vcnt_nxt_s;
      bar_r     <= bar_nxt_s;
      bar_cnt_r <= bar_cnt_nxt_s;
      l0_r      <= lfsr_step(l0_r);
      l1_r      <= lfsr_step(l1_r);
      l2_r      <= lfsr_step(l2_r);
    end
  end

  // Mode latch and frame counter, updated only at the frame boundary
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      pal_r       <= 1'b0;
      scan_r      <= 1'b0;
      pattern_r   <= 2'd0;
      frame_cnt_r <= 8'd0;
    end else if (boundary_s) begin
      pal_r       <= pal;
      scan_r      <= scandouble;
      pattern_r   <= pattern;
      frame_cnt_r <= frame_cnt_r + 8'd1;
    end
  end

  // frame_start is high only in the clock after the boundary edge
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      frame_start_r <= 1'b0;
    end else begin
      frame_start_r <= boundary_s;
    end
  end

  // Timing and colour outputs capture the current position on each pixel
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      hblank_r <= 1'b1;
      vblank_r <= 1'b1;
      hsync_r  <= 1'b0;
      vsync_r  <= 1'b0;
      r_r      <= {DW{1'b0}};
      g_r      <= {DW{1'b0}};
      b_r      <= {DW{1'b0}};
    end else if (ce_s) begin
      hblank_r <= hblank_s;
      vblank_r <= vblank_s;
      hsync_r  <= hsync_s;
      vsync_r  <= vsync_s;
      r_r      <= r_out_s;
      g_r      <= g_out_s;
      b_r      <= b_out_s;
    end
  end

  // ce_pix is forced low while reset is held
  assign ce_pix      = ce_s & reset_n;
  assign HBlank      = hblank_r;
  assign VBlank      = vblank_r;
  assign HSync       = hsync_r;
  assign VSync       = vsync_r;
  assign R           = r_r;
  assign G           = g_r;
  assign B           = b_r;
  assign frame_start = frame_start_r;
  assign frame_cnt   = frame_cnt_r;

endmodule

// File: tb/tb_video_pattern_gen.sv
// Directed bench for video_pattern_gen on a reduced raster (20x6 NTSC,
// 20x8 PAL) so that 256 frames fit in a short run.
module tb_video_pattern_gen;

  localparam int DW = 8, HW = 10, CE_DIV = 4;
  localparam int HA = 16, HT = 20, HSS = 17, HSL = 2;
  localparam int VA = 4, VTN = 6, VTP = 8, VSS = 4, VSL = 1;

  logic          clk_sys = 1'b0;
  logic          reset_n = 1'b1;
  logic          pal = 1'b0, scandouble = 1'b0;
  logic [1:0]    pattern = 2'd0;
  logic [2:0]    col_mask = 3'b111;
  logic          ce_pix, HBlank, VBlank, HSync, VSync, frame_start;
  logic [DW-1:0] R, G, B;
  logic [7:0]    frame_cnt;

  video_pattern_gen #(
    .DW(DW), .HW(HW), .CE_DIV(CE_DIV),
    .H_ACTIVE(HA), .H_TOTAL(HT), .H_SYNC_START(HSS), .H_SYNC_LEN(HSL),
    .V_ACTIVE(VA), .V_TOTAL_NTSC(VTN), .V_TOTAL_PAL(VTP),
    .V_SYNC_START(VSS), .V_SYNC_LEN(VSL)
  ) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .pal(pal), .scandouble(scandouble),
    .pattern(pattern), .col_mask(col_mask), .ce_pix(ce_pix),
    .HBlank(HBlank), .VBlank(VBlank), .HSync(HSync), .VSync(VSync),
    .R(R), .G(G), .B(B), .frame_start(frame_start), .frame_cnt(frame_cnt)
  );

  always #5 clk_sys = ~clk_sys;

  int n_assert = 0, n_fail = 0, fs_bad = 0;
  int gap, clk_n = 0;
  int nh, nv, ph, pv, vt_b;
  bit bnd_disp;
  logic [15:0] ml0, ml1, ml2, pl0, pl1, pl2;
  logic [23:0] bar_tab [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                               24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  function automatic logic [15:0] lstep(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  task automatic summary();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
  endtask

  task automatic model_reset();
    nh = 0; nv = 0; vt_b = VTN; bnd_disp = 1'b0;
    ml0 = 16'hACE1; ml1 = 16'h1D2C; ml2 = 16'h5A5A;
  endtask

  // Advance to the next ce_pix edge; afterwards the outputs show pixel (pv,ph).
  task automatic next_pix();
    bit got, c;
    got = 1'b0; gap = 0;
    for (int i = 0; i < 64 && !got; i++) begin
      @(negedge clk_sys);
      if (frame_start !== ((i == 0) && bnd_disp)) fs_bad++;
      c = ce_pix;
      @(posedge clk_sys); #1;
      gap++; clk_n++;
      if (c) got = 1'b1;
    end
    if (!got) begin
      n_assert++; n_fail++;
      $display("FAIL ce_timeout: no ce_pix within 64 clocks, required one");
      summary();
      $fatal(1, "ce_pix stalled");
    end
    ph = nh; pv = nv; pl0 = ml0; pl1 = ml1; pl2 = ml2;
    bnd_disp = (nh == HT - 1) && (nv == vt_b - 1);
    if (frame_start !== bnd_disp) fs_bad++;
    ml0 = lstep(ml0); ml1 = lstep(ml1); ml2 = lstep(ml2);
    if (nh == HT - 1) begin
      nh = 0;
      if (nv == vt_b - 1) begin
        nv = 0;
        vt_b = pal ? VTP : VTN;
      end else begin
        nv++;
      end
    end else begin
      nh++;
    end
  endtask

  // Step until the last pixel of the frame has been shown; returns pixel count.
  task automatic run_frame(output int npx);
    npx = 0;
    do begin
      next_pix();
      npx++;
    end while (!bnd_disp && npx < 1000);
  endtask

  initial begin
    int cnt, hs_cnt, hs_first, hb_cnt, hb_first, blank_rgb;
    int vs_lines, vs_first, vb_lines, vb_first, c0;
    model_reset();

    // Reset values
    #2 reset_n = 1'b0;
    repeat (3) @(negedge clk_sys);
    check("rst_ce", 32'(ce_pix), 32'd0);
    check("rst_hblank", 32'(HBlank), 32'd1);
    check("rst_vblank", 32'(VBlank), 32'd1);
    check("rst_hsync", 32'(HSync), 32'd0);
    check("rst_vsync", 32'(VSync), 32'd0);
    check("rst_rgb", 32'({R, G, B}), 32'd0);
    check("rst_fs", 32'(frame_start), 32'd0);
    check("rst_fcnt", 32'(frame_cnt), 32'd0);

    // Release; the very next clock edge is a pixel edge
    @(posedge clk_sys); #1;
    reset_n = 1'b1;
    #1 check("ce_after_release", 32'(ce_pix), 32'd1);

    // Frame 0: NTSC, pattern 0, seeds 0xACE1 -> E270 -> 7138 -> 389C
    next_pix();
    check("p0_rgb", 32'({R, G, B}), 32'hE1E1E1);
    check("p0_blank", 32'({HBlank, VBlank}), 32'd0);
    next_pix();
    check("p1_r", 32'(R), 32'h70);
    next_pix();
    check("p2_rgb", 32'({R, G, B}), 32'h383838);
    next_pix();
    check("p3_r", 32'(R), 32'h9C);
    check("period_ntsc", 32'(gap), 32'd4);

    hs_cnt = 0; hs_first = -1; hb_cnt = 0; hb_first = -1; blank_rgb = 0;
    for (int k = 0; k < 16; k++) begin
      next_pix();
      if (HSync) begin hs_cnt++; if (hs_first < 0) hs_first = ph; end
      if (HBlank) begin
        hb_cnt++;
        if (hb_first < 0) hb_first = ph;
        if ({R, G, B} != 24'd0) blank_rgb++;
      end
    end
    check("hsync_width", 32'(hs_cnt), 32'd2);
    check("hsync_first", 32'(hs_first), 32'd17);
    check("hblank_width", 32'(hb_cnt), 32'd4);
    check("hblank_first", 32'(hb_first), 32'd16);
    check("hblank_rgb_zero", 32'(blank_rgb), 32'd0);

    // Mid-frame mode changes must wait for the boundary
    pal = 1'b1; pattern = 2'd1;
    cnt = 20; vs_lines = 0; vs_first = -1; vb_lines = 0; vb_first = -1;
    do begin
      next_pix();
      cnt++;
      if (ph == 0 && VSync) begin vs_lines++; if (vs_first < 0) vs_first = pv; end
      if (ph == 0 && VBlank) begin vb_lines++; if (vb_first < 0) vb_first = pv; end
    end while (!bnd_disp && cnt < 1000);
    check("frame0_pixels", 32'(cnt), 32'd120);
    check("vsync_lines", 32'(vs_lines), 32'd1);
    check("vsync_first", 32'(vs_first), 32'd4);
    check("vblank_lines", 32'(vb_lines), 32'd2);
    check("vblank_first", 32'(vb_first), 32'd4);
    check("fs_pulse", 32'(frame_start), 32'd1);
    check("fcnt_1", 32'(frame_cnt), 32'd1);

    // Frame 1: PAL, pattern 1 against the LFSR reference
    for (int k = 0; k < 3; k++) begin
      next_pix();
      check("pat1_rgb", 32'({R, G, B}), 32'({pl0[7:0], pl1[7:0], pl2[7:0]}));
    end
    col_mask = 3'b010;
    next_pix();
    check("mask_rb_zero", 32'({R, B}), 32'd0);
    check("mask_g_kept", 32'(G), 32'(pl1[7:0]));
    col_mask = 3'b111;
    next_pix();
    check("unmask_r", 32'(R), 32'(pl0[7:0]));
    scandouble = 1'b1; pattern = 2'd2;
    next_pix();
    check("period_before_sd", 32'(gap), 32'd4);
    check("pattern_held", 32'({R, G}), 32'({pl0[7:0], pl1[7:0]}));
    run_frame(cnt);
    check("frame1_pal_pixels", 32'(cnt + 6), 32'd160);
    check("fcnt_2", 32'(frame_cnt), 32'd2);

    // Frame 2: colour bars, scandoubled pixel period
    for (int h = 0; h < HT; h++) begin
      next_pix();
      check("bar_rgb", 32'({R, G, B}), (h < HA) ? 32'(bar_tab[h / 2]) : 32'd0);
      if (h == 1) check("period_sd", 32'(gap), 32'd2);
    end
    pattern = 2'd3; pal = 1'b0;
    run_frame(cnt);
    check("frame2_pal_pixels", 32'(cnt + HT), 32'd160);
    check("fcnt_3", 32'(frame_cnt), 32'd3);

    // Frames 3,4 then gradient check in frame 5
    run_frame(cnt);
    check("frame3_ntsc_pixels", 32'(cnt), 32'd120);
    run_frame(cnt);
    check("fcnt_5", 32'(frame_cnt), 32'd5);
    next_pix();
    check("grad_h0", 32'(R), 32'd5);
    for (int k = 0; k < 10; k++) next_pix();
    check("grad_h10", 32'({R, G, B}), 32'h0F0F0F);
    run_frame(cnt);
    for (int k = 0; k < 249; k++) run_frame(cnt);
    check("fcnt_255", 32'(frame_cnt), 32'd255);
    run_frame(cnt);
    check("fcnt_wrap", 32'(frame_cnt), 32'd0);
    for (int k = 0; k < 11; k++) next_pix();
    check("grad_after_wrap", 32'(R), 32'd10);

    // Asynchronous reset mid-line
    reset_n = 1'b0;
    #1;
    check("arst_ce", 32'(ce_pix), 32'd0);
    check("arst_blank", 32'({HBlank, VBlank}), 32'd3);
    check("arst_rgb", 32'({R, G, B}), 32'd0);
    check("arst_fcnt", 32'(frame_cnt), 32'd0);
    @(posedge clk_sys); #1;
    reset_n = 1'b1;
    model_reset();
    next_pix();
    check("restart_p0", 32'({R, G, B}), 32'hE1E1E1);
    scandouble = 1'b0;
    next_pix();
    check("restart_p1", 32'(R), 32'h70);
    next_pix();
    check("period_after_rst", 32'(gap), 32'd4);
    run_frame(cnt);
    check("frame_after_rst", 32'(cnt), 32'd117);
    c0 = clk_n;
    run_frame(cnt);
    check("frame_ntsc_pixels", 32'(cnt), 32'd120);
    check("fs_spacing", 32'(clk_n - c0), 32'd480);
    check("fs_only_at_boundary", 32'(fs_bad), 32'd0);

    summary();
    $finish;
  end

endmodule
